// File: rtl/fwrisc_rd_wb_pkg.sv
// fwrisc_rd_wb shared types: register address width, zero register,
// write-back request bundle and arbiter grant encoding.
package fwrisc_rd_wb_pkg;

  localparam int REG_AW = 6;
  localparam logic [REG_AW-1:0] ZERO_REG = 6'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [31:0]       data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_EX,
    WB_SRC_MEM
  } wb_src_e;

endpackage

// File: rtl/fwrisc_rd_wb_if.sv
// Write-back sequencer bundle: claims, ex/mem result channels,
// regfile write port and hazard lookups. FWRISC_RD_WB_BYPASS_EN adds forwarding.
interface fwrisc_rd_wb_if;

  logic                                claim_valid;
  logic [fwrisc_rd_wb_pkg::REG_AW-1:0] claim_addr;

  logic                                ex_valid;
  logic                                ex_ready;
  logic [fwrisc_rd_wb_pkg::REG_AW-1:0] ex_addr;
  logic [31:0]                         ex_data;

  logic                                mem_valid;
  logic                                mem_ready;
  logic [fwrisc_rd_wb_pkg::REG_AW-1:0] mem_addr;
  logic [31:0]                         mem_data;

  logic [fwrisc_rd_wb_pkg::REG_AW-1:0] rd_waddr;
  logic [31:0]                         rd_wdata;
  logic                                rd_wen;

  logic [fwrisc_rd_wb_pkg::REG_AW-1:0] ra_raddr;
  logic [fwrisc_rd_wb_pkg::REG_AW-1:0] rb_raddr;
  logic                                ra_busy;
  logic                                rb_busy;

  logic                                claim_err;
  logic                                idle;

`ifdef FWRISC_RD_WB_BYPASS_EN
  logic                                ra_fwd_valid;
  logic [31:0]                         ra_fwd_data;
  logic                                rb_fwd_valid;
  logic [31:0]                         rb_fwd_data;
`endif

  modport slave (
    input  claim_valid, claim_addr,
    input  ex_valid, ex_addr, ex_data,
    output ex_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    output rd_waddr, rd_wdata, rd_wen,
    input  ra_raddr, rb_raddr,
    output ra_busy, rb_busy,
    output claim_err,
`ifdef FWRISC_RD_WB_BYPASS_EN
    output ra_fwd_valid, ra_fwd_data,
    output rb_fwd_valid, rb_fwd_data,
`endif
    output idle
  );

  modport master (
    output claim_valid, claim_addr,
    output ex_valid, ex_addr, ex_data,
    input  ex_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    input  rd_waddr, rd_wdata, rd_wen,
    output ra_raddr, rb_raddr,
    input  ra_busy, rb_busy,
    input  claim_err,
`ifdef FWRISC_RD_WB_BYPASS_EN
    input  ra_fwd_valid, ra_fwd_data,
    input  rb_fwd_valid, rb_fwd_data,
`endif
    input  idle
  );

endinterface

// File: rtl/fwrisc_rd_scoreboard.sv
// Busy-destination scoreboard: set on claim, clear on result acceptance,
// sticky error on double claim, two combinational lookups.
module fwrisc_rd_scoreboard
  import fwrisc_rd_wb_pkg::*;
#(
  parameter int                NREGS     = 64,
  parameter logic [REG_AW-1:0] ZERO_ADDR = ZERO_REG
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              set_valid,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_valid,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] a_addr,
  output logic              a_busy,
  input  logic [REG_AW-1:0] b_addr,
  output logic              b_busy,
  output logic              any_busy,
  output logic              claim_err
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             set_en;
  logic             clr_en;
  logic             conflict;

  // Clear first so a same-cycle claim on the same address wins.
  always_comb begin
    set_en   = set_valid && (set_addr != ZERO_ADDR);
    clr_en   = clr_valid && (clr_addr != ZERO_ADDR);
    conflict = set_en && busy[set_addr] &&
               !(clr_en && (clr_addr == set_addr));
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
  end

  // Busy vector and sticky claim error.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy      <= '0;
      claim_err <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (conflict) claim_err <= 1'b1;
    end
  end

  assign a_busy   = busy[a_addr];
  assign b_busy   = busy[b_addr];
  assign any_busy = |busy;

endmodule

// File: rtl/fwrisc_rd_wb.sv
// Write-back sequencer: mem-priority arbiter, one registered regfile write
// stage, scoreboard-backed hazards. Optional FWRISC_RD_WB_BYPASS_EN forwarding.
module fwrisc_rd_wb #(
  parameter int          NREGS    = 64,
  parameter logic [5:0]  ZERO_REG = fwrisc_rd_wb_pkg::ZERO_REG
) (
  input logic           clock,
  input logic           reset,
  fwrisc_rd_wb_if.slave wb
);

  fwrisc_rd_wb_pkg::wb_src_e grant;
  fwrisc_rd_wb_pkg::wb_req_t req;
  logic                      acc;
  logic                      wr_en;
  logic                      sb_a;
  logic                      sb_b;
  logic                      stage_a;
  logic                      stage_b;
  logic                      any_busy;

  assign wb.mem_ready = !reset;
  assign wb.ex_ready  = !reset && !wb.mem_valid;

  // Pick the single result transferring this cycle; mem always wins.
  always_comb begin
    grant = fwrisc_rd_wb_pkg::WB_SRC_NONE;
    req   = '0;
    unique case (1'b1)
      (wb.mem_valid && wb.mem_ready): begin
        grant = fwrisc_rd_wb_pkg::WB_SRC_MEM;
        req   = '{addr: wb.mem_addr, data: wb.mem_data};
      end
      (wb.ex_valid && wb.ex_ready): begin
        grant = fwrisc_rd_wb_pkg::WB_SRC_EX;
        req   = '{addr: wb.ex_addr, data: wb.ex_data};
      end
      default: ;
    endcase
  end

  assign acc   = (grant != fwrisc_rd_wb_pkg::WB_SRC_NONE);
  assign wr_en = acc && (req.addr != ZERO_REG);

  // Output stage; zero-register results are swallowed without a write.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb.rd_wen   <= 1'b0;
      wb.rd_waddr <= '0;
      wb.rd_wdata <= '0;
    end else begin
      wb.rd_wen <= wr_en;
      if (wr_en) begin
        wb.rd_waddr <= req.addr;
        wb.rd_wdata <= req.data;
      end
    end
  end

  fwrisc_rd_scoreboard #(
    .NREGS     (NREGS),
    .ZERO_ADDR (ZERO_REG)
  ) u_sb (
    .clock     (clock),
    .reset     (reset),
    .set_valid (wb.claim_valid),
    .set_addr  (wb.claim_addr),
    .clr_valid (acc),
    .clr_addr  (req.addr),
    .a_addr    (wb.ra_raddr),
    .a_busy    (sb_a),
    .b_addr    (wb.rb_raddr),
    .b_busy    (sb_b),
    .any_busy  (any_busy),
    .claim_err (wb.claim_err)
  );

  assign stage_a = wb.rd_wen && (wb.rd_waddr == wb.ra_raddr) &&
                   (wb.ra_raddr != ZERO_REG);
  assign stage_b = wb.rd_wen && (wb.rd_waddr == wb.rb_raddr) &&
                   (wb.rb_raddr != ZERO_REG);

`ifdef FWRISC_RD_WB_BYPASS_EN
  assign wb.ra_busy      = sb_a;
  assign wb.rb_busy      = sb_b;
  assign wb.ra_fwd_valid = stage_a;
  assign wb.ra_fwd_data  = wb.rd_wdata;
  assign wb.rb_fwd_valid = stage_b;
  assign wb.rb_fwd_data  = wb.rd_wdata;
`else
  assign wb.ra_busy = sb_a || stage_a;
  assign wb.rb_busy = sb_b || stage_b;
`endif

  assign wb.idle = !any_busy && !wb.rd_wen;

endmodule

// File: tb/tb_fwrisc_rd_wb.sv
// Directed vector bench for fwrisc_rd_wb; optional
// FWRISC_RD_WB_BYPASS_EN checks forwarding.
module tb_fwrisc_rd_wb;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  fwrisc_rd_wb_if wb();

  fwrisc_rd_wb dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        cv;
    logic [5:0]  ca;
    logic        ev;
    logic [5:0]  ea;
    logic [31:0] ed;
    logic        mv;
    logic [5:0]  ma;
    logic [31:0] md;
    logic [5:0]  ra;
    logic [5:0]  rb;
    logic        x_er;
    logic        x_mr;
    logic        x_wen;
    logic        chk_wr;
    logic [5:0]  x_wa;
    logic [31:0] x_wd;
    logic        x_sa;
    logic        x_sb;
    logic        x_err;
    logic        x_idle;
  } vec_t;

  vec_t v[20];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    wb.claim_valid = t.cv;
    wb.claim_addr  = t.ca;
    wb.ex_valid    = t.ev;
    wb.ex_addr     = t.ea;
    wb.ex_data     = t.ed;
    wb.mem_valid   = t.mv;
    wb.mem_addr    = t.ma;
    wb.mem_data    = t.md;
    wb.ra_raddr    = t.ra;
    wb.rb_raddr    = t.rb;
  endtask

  task automatic quiet();
    vec_t z;
    z = '{default: '0};
    drive(z);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_vec(input int i, input vec_t t);
    logic st_a;
    logic st_b;
    st_a = t.x_wen && (t.x_wa == t.ra) && (t.ra != 6'd0);
    st_b = t.x_wen && (t.x_wa == t.rb) && (t.rb != 6'd0);
    chk($sformatf("v%0d ex_ready", i), 32'(wb.ex_ready), 32'(t.x_er));
    chk($sformatf("v%0d mem_ready", i), 32'(wb.mem_ready), 32'(t.x_mr));
    chk($sformatf("v%0d rd_wen", i), 32'(wb.rd_wen), 32'(t.x_wen));
    if (t.chk_wr) begin
      chk($sformatf("v%0d rd_waddr", i), 32'(wb.rd_waddr), 32'(t.x_wa));
      chk($sformatf("v%0d rd_wdata", i), wb.rd_wdata, t.x_wd);
    end
`ifdef FWRISC_RD_WB_BYPASS_EN
    chk($sformatf("v%0d ra_busy", i), 32'(wb.ra_busy), 32'(t.x_sa));
    chk($sformatf("v%0d rb_busy", i), 32'(wb.rb_busy), 32'(t.x_sb));
    chk($sformatf("v%0d ra_fwd_valid", i), 32'(wb.ra_fwd_valid), 32'(st_a));
    chk($sformatf("v%0d rb_fwd_valid", i), 32'(wb.rb_fwd_valid), 32'(st_b));
`else
    chk($sformatf("v%0d ra_busy", i), 32'(wb.ra_busy), 32'(t.x_sa || st_a));
    chk($sformatf("v%0d rb_busy", i), 32'(wb.rb_busy), 32'(t.x_sb || st_b));
`endif
    chk($sformatf("v%0d claim_err", i), 32'(wb.claim_err), 32'(t.x_err));
    chk($sformatf("v%0d idle", i), 32'(wb.idle), 32'(t.x_idle));
  endtask

  initial begin
    // cv ca ev ea ed mv ma md ra rb | er mr wen chk wa wd sa sb err idle
    v[0]  = '{0,0, 0,0,0, 0,0,0, 5,0, 1,1,0,1, 0,0, 0,0,0,1};
    v[1]  = '{1,5, 0,0,0, 0,0,0, 5,0, 1,1,0,1, 0,0, 0,0,0,1};
    v[2]  = '{0,0, 1,5,32'hDEADBEEF, 0,0,0, 5,0,
              1,1,0,1, 0,0, 1,0,0,0};
    v[3]  = '{0,0, 0,0,0, 0,0,0, 5,0,
              1,1,1,1, 5,32'hDEADBEEF, 0,0,0,0};
    v[4]  = '{0,0, 0,0,0, 0,0,0, 5,0,
              1,1,0,1, 5,32'hDEADBEEF, 0,0,0,1};
    v[5]  = '{0,0, 1,3,32'h11, 1,4,32'h22, 4,3,
              0,1,0,1, 5,32'hDEADBEEF, 0,0,0,1};
    v[6]  = '{0,0, 1,3,32'h11, 0,0,0, 4,3,
              1,1,1,1, 4,32'h22, 0,0,0,0};
    v[7]  = '{0,0, 0,0,0, 0,0,0, 4,3, 1,1,1,1, 3,32'h11, 0,0,0,0};
    v[8]  = '{0,0, 1,0,32'h1234, 0,0,0, 0,3,
              1,1,0,1, 3,32'h11, 0,0,0,1};
    v[9]  = '{1,0, 0,0,0, 0,0,0, 0,0, 1,1,0,0, 0,0, 0,0,0,1};
    v[10] = '{0,0, 0,0,0, 0,0,0, 0,0, 1,1,0,0, 0,0, 0,0,0,1};
    v[11] = '{1,7, 0,0,0, 0,0,0, 7,0, 1,1,0,0, 0,0, 0,0,0,1};
    v[12] = '{1,7, 0,0,0, 0,0,0, 7,0, 1,1,0,0, 0,0, 1,0,0,0};
    v[13] = '{0,0, 1,7,32'h77, 0,0,0, 7,0,
              1,1,0,0, 0,0, 1,0,1,0};
    v[14] = '{0,0, 0,0,0, 0,0,0, 7,0, 1,1,1,1, 7,32'h77, 0,0,1,0};
    v[15] = '{1,9, 0,0,0, 1,9,32'h99, 9,0,
              0,1,0,1, 7,32'h77, 0,0,1,1};
    v[16] = '{0,0, 0,0,0, 0,0,0, 9,0, 1,1,1,1, 9,32'h99, 1,0,1,0};
    v[17] = '{0,0, 1,9,32'h5, 0,0,0, 0,9,
              1,1,0,1, 9,32'h99, 0,1,1,0};
    v[18] = '{0,0, 0,0,0, 0,0,0, 0,9, 1,1,1,1, 9,32'h5, 0,0,1,0};
    v[19] = '{0,0, 0,0,0, 0,0,0, 0,9, 1,1,0,1, 9,32'h5, 0,0,1,1};

    quiet();
    reset = 1'b1;
    wb.claim_valid = 1'b1;
    wb.claim_addr  = 6'd10;
    wb.ex_valid    = 1'b1;
    wb.ex_addr     = 6'd11;
    wb.ex_data     = 32'hAA;
    wb.mem_valid   = 1'b1;
    wb.mem_addr    = 6'd12;
    wb.mem_data    = 32'hBB;
    wb.ra_raddr    = 6'd10;
    wb.rb_raddr    = 6'd12;
    step();
    step();
    chk("rst ex_ready", 32'(wb.ex_ready), 32'd0);
    chk("rst mem_ready", 32'(wb.mem_ready), 32'd0);
    chk("rst rd_wen", 32'(wb.rd_wen), 32'd0);
    chk("rst rd_waddr", 32'(wb.rd_waddr), 32'd0);
    chk("rst rd_wdata", wb.rd_wdata, 32'd0);
    chk("rst claim_err", 32'(wb.claim_err), 32'd0);
    quiet();
    wb.ra_raddr = 6'd10;
    wb.rb_raddr = 6'd12;
    reset = 1'b0;
    step();
    chk("post-rst idle", 32'(wb.idle), 32'd1);
    chk("post-rst ra_busy", 32'(wb.ra_busy), 32'd0);
    chk("post-rst rb_busy", 32'(wb.rb_busy), 32'd0);
    chk("post-rst rd_wen", 32'(wb.rd_wen), 32'd0);

    for (int i = 0; i < 20; i++) begin
      drive(v[i]);
      #1;
      check_vec(i, v[i]);
      step();
    end

`ifdef FWRISC_RD_WB_BYPASS_EN
    quiet();
    wb.claim_valid = 1'b1;
    wb.claim_addr  = 6'd12;
    step();
    quiet();
    wb.ex_valid = 1'b1;
    wb.ex_addr  = 6'd12;
    wb.ex_data  = 32'hCAFE0001;
    wb.ra_raddr = 6'd12;
    #1;
    chk("byp pre ra_busy", 32'(wb.ra_busy), 32'd1);
    step();
    quiet();
    wb.ra_raddr = 6'd12;
    #1;
    chk("byp ra_fwd_valid", 32'(wb.ra_fwd_valid), 32'd1);
    chk("byp ra_fwd_data", wb.ra_fwd_data, 32'hCAFE0001);
    chk("byp ra_busy", 32'(wb.ra_busy), 32'd0);
    chk("byp rb_fwd_valid", 32'(wb.rb_fwd_valid), 32'd0);
    step();
`endif

    quiet();
    wb.claim_valid = 1'b1;
    wb.claim_addr  = 6'd13;
    wb.ex_valid    = 1'b1;
    wb.ex_addr     = 6'd13;
    wb.ex_data     = 32'h1313;
    reset = 1'b1;
    step();
    chk("mid-rst rd_wen", 32'(wb.rd_wen), 32'd0);
    chk("mid-rst rd_waddr", 32'(wb.rd_waddr), 32'd0);
    chk("mid-rst rd_wdata", wb.rd_wdata, 32'd0);
    chk("mid-rst claim_err", 32'(wb.claim_err), 32'd0);
    quiet();
    wb.ra_raddr = 6'd13;
    reset = 1'b0;
    step();
    chk("drop rd_wen", 32'(wb.rd_wen), 32'd0);
    chk("drop idle", 32'(wb.idle), 32'd1);
    chk("drop ra_busy", 32'(wb.ra_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fwrisc_rd_wb.md
Name: fwrisc_rd_wb

Overview:
- Write-back sequencer and scoreboard: the producer side of the fwrisc_regfile write port.
- Accepts destination-register results from the execute stage and the load/store unit over valid/ready channels.
- Arbitrates them, drives rd_waddr/rd_wdata/rd_wen through one registered stage, and tracks in-flight destinations.
- Read-side hazard checks for ra/rb therefore come from one place.

Parameters:
- NREGS, 64, registers tracked; equals the regfile depth (6-bit address).
- ZERO_REG, 0, address that is never written or marked busy.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- claim_valid  in  1  issue stage marks a destination as pending this cycle
- claim_addr  in  6  destination being claimed
- ex_valid  in  1  execute result valid
- ex_ready  out  1  execute result accepted
- ex_addr  in  6  execute destination
- ex_data  in  32  execute result
- mem_valid  in  1  load result valid
- mem_ready  out  1  load result accepted
- mem_addr  in  6  load destination
- mem_data  in  32  load result
- rd_waddr  out  6  regfile write address
- rd_wdata  out  32  regfile write data
- rd_wen  out  1  regfile write enable
- ra_raddr  in  6  operand-A address being read
- rb_raddr  in  6  operand-B address being read
- ra_busy  out  1  operand A has a pending write
- rb_busy  out  1  operand B has a pending write
- claim_err  out  1  sticky: claim made to an already-busy register
- idle  out  1  no pending destinations and output stage empty

Behaviour:
- Reset (synchronous, sampled on posedge clock):
  - busy bitmap = 0; rd_wen = 0; rd_waddr = 0; rd_wdata = 0; claim_err = 0.
  - Outputs reach these values on the first edge with reset high.
  - Reset mid-transfer drops the staged write; it is never issued.
- Arbitration, one result per cycle:
  - mem has fixed priority; mem_ready = 1 whenever not in reset.
  - ex_ready = !mem_valid; reset forces both readies low.
  - A transfer occurs when valid && ready at the edge.
- Output stage:
  - An accepted result is registered; rd_wen/rd_waddr/rd_wdata are valid exactly one cycle after acceptance.
  - With no transfer, rd_wen = 0 the next cycle; rd_waddr/rd_wdata hold their last values.
- Zero register: an accepted result with addr == ZERO_REG is consumed (ready asserted) but produces rd_wen = 0.
- Scoreboard (NREGS-bit busy vector):
  - Set: claim_valid && claim_addr != ZERO_REG, at the edge.
  - Clear: on acceptance of a result for that address, at the same edge the output stage loads. Busy drops when the write is staged, not when it is committed.
  - Same-cycle claim and clear on one address: busy ends at 1 (set wins).
  - Claim on an address already busy and not cleared that cycle: claim_err set, stays set until reset; busy stays 1.
  - A result to a non-busy address is still written; the scoreboard is unchanged.
- Hazard outputs:
  - ra_busy = busy[ra_raddr] || (rd_wen && rd_waddr == ra_raddr && ra_raddr != ZERO_REG).
  - rb_busy uses the same rule with rb_raddr.
  - Both are combinational from registered state.
  - The staged-write term covers the regfile write landing at the end of that cycle.
- idle = (busy == 0) && !rd_wen.

Optional Feature:
- Macro: FWRISC_RD_WB_BYPASS_EN.
- When defined, adds outputs:
  - ra_fwd_valid (1): high when the staged write matches ra_raddr and ra_raddr != ZERO_REG.
  - ra_fwd_data (32) = rd_wdata.
  - rb_fwd_valid / rb_fwd_data: same rule for rb_raddr.
  - ra_busy/rb_busy then exclude the staged-write term, so forwarded operands do not stall.
- When undefined: those ports do not exist and the hazard outputs behave as in Behaviour.

Decomposition:
- Package fwrisc_rd_wb_pkg holds:
  - localparam REG_AW = 6 and ZERO_REG.
  - typedef wb_req_t {addr[5:0], data[31:0]}.
  - typedef wb_src_e {WB_SRC_NONE, WB_SRC_EX, WB_SRC_MEM} for the arbiter grant.
- One sub-module: fwrisc_rd_scoreboard. It holds the busy vector and claim_err, and exposes set/clear ports plus two lookup ports.
- Arbitration and the output stage stay in the top module.

Test Plan:
- Reset: drive claim/ex/mem during reset high -> busy = 0, rd_wen = 0, claim_err = 0, idle = 1 after release.
- Simple write:
  - Claim x5, then ex_valid addr=5 data=0xDEADBEEF.
  - Expect ra_raddr=5 reports ra_busy=1 from claim until the write stage.
  - Next cycle rd_wen=1, rd_waddr=5, rd_wdata=0xDEADBEEF; cycle after, ra_busy=0 and idle=1.
- Collision:
  - ex (addr 3, 0x11) and mem (addr 4, 0x22) valid together.
  - Expect mem_ready=1, ex_ready=0; write 4/0x22, then ex accepted and 3/0x11 written the following cycle.
- Zero register: ex addr=0, data=0x1234 -> ex_ready=1, no rd_wen, busy unchanged; claim addr 0 -> ra_busy for raddr 0 stays 0.
- Claim conflicts:
  - Claim 7 twice with no intervening result -> claim_err=1 and stays 1 across later writes.
  - Same-cycle claim 9 plus mem result 9 -> busy[9]=1 afterwards.
- Bypass (macro defined): staged write to 12 = 0xCAFE0001 with ra_raddr=12 -> ra_fwd_valid=1, ra_fwd_data=0xCAFE0001, ra_busy=0.
